// File: rtl/ysyx_22050019_lsu_if.sv
// Bus bundle between the MEM stage, the load/store unit and the data cache.
// The master modport is the LSU view; slave is the pipeline/cache environment view.
interface ysyx_22050019_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wen;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    r_valid;
  logic                    r_ready;
  logic [1:0]              r_resp;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;

  modport master (
    input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_strb, w_data, b_ready,
    input  ar_ready, r_valid, r_resp, r_data, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_strb, w_data, b_ready,
    output ar_ready, r_valid, r_resp, r_data, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/ysyx_22050019_lsu.sv
// Load/store unit: one outstanding request, translated onto the cache ar/r or aw/w/b
// channels, with lane alignment of store data and extension of load data.
module ysyx_22050019_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ysyx_22050019_lsu_if.master  bus
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return STRB_W'(8'h01);
      2'd1:    return STRB_W'(8'h03);
      2'd2:    return STRB_W'(8'h0F);
      2'd3:    return STRB_W'(8'hFF);
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] x,
                                                   input logic [1:0] size,
                                                   input logic uns);
    case (size)
      2'd0:    return {{(DATA_WIDTH-8){~uns & x[7]}}, x[7:0]};
      2'd1:    return {{(DATA_WIDTH-16){~uns & x[15]}}, x[15:0]};
      2'd2:    return {{(DATA_WIDTH-32){~uns & x[31]}}, x[31:0]};
      2'd3:    return x;
      default: return '0;
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;

  logic [5:0]              sh_s;
  logic [ADDR_WIDTH-1:0]   aligned_s;

  assign sh_s      = {addr_q[2:0], 3'b000};
  assign aligned_s = {addr_q[ADDR_WIDTH-1:3], 3'b000};

  // The cache ORs both address buses, so the idle channel must always read zero.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.ar_valid   = (state_q == S_AR);
  assign bus.ar_addr    = (state_q == S_AR) ? aligned_s : '0;
  assign bus.r_ready    = (state_q == S_R);
  assign bus.aw_valid   = (state_q == S_AW);
  assign bus.aw_addr    = (state_q == S_AW) ? aligned_s : '0;
  assign bus.w_valid    = (state_q == S_W);
  assign bus.w_data     = (state_q == S_W) ? (wdata_q << sh_s) : '0;
  assign bus.w_strb     = (state_q == S_W) ? (size_mask(size_q) << addr_q[2:0]) : '0;
  assign bus.b_ready    = (state_q == S_B);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // Next-state, request latch and completion response computation.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
          if (misaligned(bus.req_size, bus.req_addr[2:0])) begin
            state_d = S_ERR;
          end else if (bus.req_wen) begin
            state_d = S_AW;
          end else begin
            state_d = S_AR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        if (bus.ar_ready) begin
          state_d = S_R;
        end else begin
          state_d = S_AR;
        end
      end
      S_R: begin
        if (bus.r_valid) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = |bus.r_resp;
          resp_rdata_d = (|bus.r_resp) ? '0 : extend(bus.r_data >> sh_s, size_q, uns_q);
        end else begin
          state_d = S_R;
        end
      end
      S_AW: begin
        if (bus.aw_ready) begin
          state_d = S_W;
        end else begin
          state_d = S_AW;
        end
      end
      S_W: begin
        if (bus.w_ready) begin
          state_d = S_B;
        end else begin
          state_d = S_W;
        end
      end
      S_B: begin
        if (bus.b_valid) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = |bus.b_resp;
        end else begin
          state_d = S_B;
        end
      end
      S_ERR: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and response registers; reset drops any in-flight transaction silently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
